// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared state encoding, default widths and occupancy decode
//               for the handshaked pipeline-stage register.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Default widths of the stage payload, control field and stall counter
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CTRL_W = 4;
  localparam int unsigned DEF_CNT_W  = 16;

  // Storage state: nothing held, main slot only, main plus skid slot
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Number of entries held in a given state
  function automatic logic [1:0] occ_of(input state_e s);
    case (s)
      ST_FULL: occ_of = 2'd1;
      ST_SKID: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One ctrl+data entry register with load enable and a
//               ctrl-only clear used to turn the entry into a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clr_ctrl_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Clearing wins over loading; payload is left untouched by a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else if (clr_ctrl_i) begin
      ctrl_q <= '0;
    end else if (load_i) begin
      ctrl_q <= ctrl_i;
      data_q <= data_i;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_hs
// Description : Valid/ready pipeline-stage register with a one-entry skid
//               buffer, synchronous flush and saturating stall counter.
//               in_ready depends on registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] C_STALL_MAX = '1;

  state_e            state_q, state_d;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [1:0]        occ_q;
  logic [CNT_W-1:0]  stall_q;

  logic              w_in_fire, w_out_fire;
  logic              w_main_load, w_main_from_skid, w_main_clr;
  logic              w_skid_load, w_skid_clr;
  logic [CTRL_W-1:0] w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data_d;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  assign w_in_fire  = in_valid & in_ready_q;
  assign w_out_fire = out_valid_q & out_ready;

  // Next-state and slot-control decode; flush overrides every transition
  always_comb begin
    state_d          = state_q;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_clr       = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clr       = 1'b0;
    if (flush) begin
      state_d    = ST_EMPTY;
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_in_fire) begin
            state_d     = ST_FULL;
            w_main_load = 1'b1;
          end
        end
        ST_FULL: begin
          case ({w_in_fire, w_out_fire})
            2'b11: w_main_load = 1'b1;
            2'b01: begin
              // Draining to empty: zero ctrl so the output reads as a bubble
              state_d    = ST_EMPTY;
              w_main_clr = 1'b1;
            end
            2'b10: begin
              state_d     = ST_SKID;
              w_skid_load = 1'b1;
            end
            default: ;
          endcase
        end
        ST_SKID: begin
          if (w_out_fire) begin
            state_d          = ST_FULL;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign w_main_ctrl_d = w_main_from_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_data_d = w_main_from_skid ? w_skid_data : in_data;

  // State register with handshake outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_SKID);
      occ_q       <= occ_of(state_d);
    end
  end

  // Saturating count of cycles where downstream back-pressures a valid entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != C_STALL_MAX)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk        (clk),
    .reset      (reset),
    .load_i     (w_main_load),
    .clr_ctrl_i (w_main_clr),
    .ctrl_i     (w_main_ctrl_d),
    .data_i     (w_main_data_d),
    .ctrl_o     (out_ctrl),
    .data_o     (out_data)
  );

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .load_i     (w_skid_load),
    .clr_ctrl_i (w_skid_clr),
    .ctrl_i     (in_ctrl),
    .data_i     (in_data),
    .ctrl_o     (w_skid_ctrl),
    .data_o     (w_skid_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_hs
// Description : Self-checking bench for pipe_stage_hs: per-cycle vector table
//               for handshake/occupancy/stall, scoreboard for payload order,
//               directed sequences for saturation and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_hs;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int          NVEC   = 23;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  typedef struct {
    logic        in_valid;
    logic [3:0]  in_ctrl;
    logic [31:0] in_data;
    logic        out_ready;
    logic        flush;
    logic        exp_ov;
    logic        exp_ir;
    logic [1:0]  exp_occ;
    logic [3:0]  exp_stall;
  } vec_t;

  vec_t vecs [NVEC];
  logic [CTRL_W+DATA_W-1:0] sb [$];
  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_hs #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard snapshot at the falling edge (inputs and outputs stable), then
  // advance past the next rising edge.
  task automatic tick();
    logic [CTRL_W+DATA_W-1:0] e;
    @(negedge clk);
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", out_data, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("sb_data", out_data, e[DATA_W-1:0]);
          check("sb_ctrl", {28'd0, out_ctrl}, {28'd0, e[CTRL_W+DATA_W-1:DATA_W]});
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] d,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    // {in_valid, ctrl, data, out_ready, flush, exp_ov, exp_ir, exp_occ, exp_stall}
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 4'(i + 1), 32'(i + 1), 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'd0};
    vecs[8]  = '{1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0};
    vecs[9]  = '{1'b1, 4'h1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'd0};
    vecs[10] = '{1'b1, 4'h2, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'd1};
    vecs[11] = '{1'b1, 4'h9, 32'h99, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'd2};
    vecs[12] = '{1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'd2};
    vecs[13] = '{1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd2};
    vecs[14] = '{1'b1, 4'h4, 32'h44, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'd2};
    vecs[15] = '{1'b1, 4'h5, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'd3};
    vecs[16] = '{1'b1, 4'h3, 32'h33, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'd4};
    vecs[17] = '{1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd4};
    vecs[18] = '{1'b1, 4'h6, 32'h66, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'd4};
    vecs[19] = '{1'b0, 4'h0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 4'd4};
    vecs[20] = '{1'b1, 4'h7, 32'h77, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'd4};
    vecs[21] = '{1'b1, 4'h8, 32'h78, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'd4};
    vecs[22] = '{1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd4};

    // Reset held with an upstream entry offered
    reset = 1'b1;
    drive(1'b1, 4'hA, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_ctrl",  {28'd0, out_ctrl}, 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);

    // First accept after release: one-cycle latency
    reset = 1'b0;
    tick();
    check("first_out_valid", {31'd0, out_valid}, 32'd1);
    check("first_out_data",  out_data, 32'hDEAD_BEEF);
    check("first_out_ctrl",  {28'd0, out_ctrl}, 32'hA);
    check("first_occupancy", {30'd0, occupancy}, 32'd1);
    drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check("drain_out_ctrl",  {28'd0, out_ctrl}, 32'd0);

    // Vector table: streaming, skid fill/drain, flush cases
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].in_valid, vecs[i].in_ctrl, vecs[i].in_data, vecs[i].out_ready, vecs[i].flush);
      tick();
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_ov});
      check($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].exp_ir});
      check($sformatf("vec%0d_occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].exp_occ});
      check($sformatf("vec%0d_stall_cnt", i), {28'd0, stall_cnt}, {28'd0, vecs[i].exp_stall});
      if (!vecs[i].exp_ov)
        check($sformatf("vec%0d_bubble_ctrl", i), {28'd0, out_ctrl}, 32'd0);
    end

    // Stall counter saturation, then flush leaves it alone
    drive(1'b1, 4'hF, 32'hAB, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall_cnt", {28'd0, stall_cnt}, 32'd15);
    check("sat_out_valid", {31'd0, out_valid}, 32'd1);
    check("sat_out_data",  out_data, 32'hAB);
    drive(1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check("sat_flush_stall_cnt", {28'd0, stall_cnt}, 32'd15);
    check("sat_flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("sat_flush_out_ctrl",  {28'd0, out_ctrl}, 32'd0);

    // Asynchronous reset with two entries held
    drive(1'b1, 4'h8, 32'h88, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'h9, 32'h99, 1'b0, 1'b0);
    tick();
    check("pre_arst_occupancy", {30'd0, occupancy}, 32'd2);
    drive(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_ctrl",  {28'd0, out_ctrl}, 32'd0);
    check("arst_out_data",  out_data, 32'd0);
    check("arst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("arst_occupancy", {30'd0, occupancy}, 32'd0);
    check("arst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    sb.delete();
    tick();
    reset = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("post_arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
